// File: rtl/gpio_arb_pkg.sv
// Shared types and helpers for the GPIO APB arbiter.
// Round-robin pick function and FSM state encoding.
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int STRB_W     = DATA_W_DEF / 8;
  localparam int MAX_REQ    = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_t;

  // First set bit searching upward from last+1, wrapping modulo n.
  function automatic rr_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         last,
    input int                 n
  );
    rr_t r;
    int  j;
    r = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      j = (int'(last) + i) % n;
      if (i <= n && !r.found && req[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Round-robin arbiter for the GPIO APB requesters.
// Holds the last grant; advances only when a grant is consumed.
module gpio_rr_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            pclk,
  input  logic            prstn,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] last_q;
  rr_t           pick;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req), 3'(last_q), NREQ);
  end

  assign any   = pick.found;
  assign idx   = IW'(pick.idx);
  assign grant = pick.found ? (NREQ'(1) << idx) : '0;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      last_q <= IW'(NREQ - 1);
    end else if (advance && pick.found) begin
      last_q <= idx;
    end
  end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Shares one GPIO APB4 completer between NREQ requesters.
// Round-robin grant, SETUP/ACCESS sequencing, access watchdog.
module gpio_apb_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DATA_W     = 32,
  parameter int PADDR_SIZE = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                     pclk,
  input  logic                     prstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*PADDR_SIZE-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*DATA_W/8-1:0] req_strb,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [PADDR_SIZE-1:0]    paddr,
  output logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W/8-1:0]      pstrb,
  input  logic                     pready,
  input  logic                     pslverr,
  input  logic [DATA_W-1:0]        prdata
);

  localparam int SW  = DATA_W / 8;
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT);

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   cur_idx;
  logic            any;
  logic            arb_en;
  logic            done;
  logic            tmo;
  logic            cmd_write;
  logic [SW-1:0]   cmd_strb;
  logic [WDW-1:0]  wd;

  gpio_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .pclk   (pclk),
    .prstn  (prstn),
    .req    (req_valid),
    .advance(arb_en),
    .grant  (grant),
    .idx    (gidx),
    .any    (any)
  );

  assign tmo    = (wd == WDW'(TIMEOUT - 1));
  assign done   = (state == ACCESS) && (pready || tmo);
  // Arbitrating in the completing ACCESS cycle gives 2-cycle streaming.
  assign arb_en = (state == IDLE) || done;

  assign req_ready = arb_en ? grant : '0;
  assign pwrite    = cmd_write;
  assign pstrb     = cmd_write ? cmd_strb : '0;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      cmd_strb  <= '0;
      cmd_write <= 1'b0;
      cur_idx   <= '0;
      wd        <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (arb_en && any) begin
        cmd_write <= req_write[gidx];
        paddr     <= req_addr[int'(gidx)*PADDR_SIZE +: PADDR_SIZE];
        pwdata    <= req_wdata[int'(gidx)*DATA_W +: DATA_W];
        cmd_strb  <= req_strb[int'(gidx)*SW +: SW];
        cur_idx   <= gidx;
      end
      unique case (state)
        IDLE: begin
          if (any) begin
            state <= SETUP;
            psel  <= 1'b1;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid <= NREQ'(1) << cur_idx;
            rsp_rdata <= cmd_write ? '0 : prdata;
            rsp_err   <= pready ? pslverr : 1'b1;
            wd        <= '0;
            penable   <= 1'b0;
            if (any) begin
              state <= SETUP;
            end else begin
              state <= IDLE;
              psel  <= 1'b0;
            end
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Scoreboard bench for gpio_apb_arbiter.
// Completer model with programmable wait states and error address.
module tb_gpio_apb_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int TO   = 16;
  localparam int SW   = DW / 8;

  logic               pclk = 1'b0;
  logic               prstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ*SW-1:0] req_strb;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [SW-1:0]      pstrb;
  logic               pready;
  logic               pslverr;
  logic [DW-1:0]      prdata;

  typedef struct {
    int          idx;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    int          len;
  } exp_t;

  exp_t   exp_q[$];
  int     grant_q[$];
  longint gcyc_q[$];
  exp_t   mon_e;
  exp_t   mon_t;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     ws       = 0;
  int     err_addr = -1;
  logic [31:0] rd_base = '0;
  longint cyc = 0;
  int     run = 0;
  int     wcnt = 0;

  gpio_apb_arbiter #(
    .NREQ(NREQ), .DATA_W(DW), .PADDR_SIZE(AW), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .prstn(prstn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_strb(req_strb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
    .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Completer: ws wait states (ws >= 100 means never ready).
  initial begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    forever begin
      @(posedge pclk);
      #1;
      prdata = rd_base + 32'(paddr);
      if (psel && penable) begin
        pready  = (ws < 100) && (wcnt == ws);
        pslverr = pwrite && (int'(paddr) == err_addr);
        wcnt++;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Monitor: pop on rsp_valid, check APB vs in-flight, push on req_ready.
  initial begin
    forever begin
      @(negedge pclk);
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 128'(rsp_valid), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_valid", 128'(rsp_valid), 128'(1 << mon_e.idx));
          check("rsp_rdata", 128'(rsp_rdata), 128'(mon_e.rdata));
          check("rsp_err", 128'(rsp_err), 128'(mon_e.err));
          check("acc_len", 128'(run), 128'(mon_e.len));
        end
      end
      if (psel) begin
        if (exp_q.size() == 0) begin
          check("apb_no_cmd", 128'(psel), 128'(0));
        end else begin
          mon_t = exp_q[$];
          check("paddr", 128'(paddr), 128'(mon_t.addr));
          check("pwrite", 128'(pwrite), 128'(mon_t.wr));
          check("pstrb", 128'(pstrb),
                128'(mon_t.wr ? mon_t.strb : 4'h0));
          if (mon_t.wr)
            check("pwdata", 128'(pwdata), 128'(mon_t.wdata));
        end
      end
      run = (psel && penable) ? run + 1 : 0;
      if (req_ready != '0) begin
        int gi;
        gi = 0;
        check("ready_onehot", 128'($onehot(req_ready)), 128'(1));
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
        mon_e.idx   = gi;
        mon_e.wr    = req_write[gi];
        mon_e.addr  = req_addr[gi*AW +: AW];
        mon_e.wdata = req_wdata[gi*DW +: DW];
        mon_e.strb  = req_strb[gi*SW +: SW];
        mon_e.rdata = mon_e.wr ? 32'h0 : rd_base + 32'(mon_e.addr);
        mon_e.err   = (ws >= 100) ? 1'b1 :
                      (mon_e.wr && int'(mon_e.addr) == err_addr);
        mon_e.len   = (ws >= 100) ? TO : ws + 1;
        exp_q.push_back(mon_e);
        grant_q.push_back(gi);
        gcyc_q.push_back(cyc);
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input int i, input logic wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit got;
    got = 0;
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW] = s;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge pclk);
      if (req_ready[i]) got = 1;
    end
    if (!got) check("ready_wait", 128'(0), 128'(1));
    @(posedge pclk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge pclk);
    check("drain", 128'(exp_q.size()), 128'(0));
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    prstn     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    repeat (3) @(negedge pclk);
    check("rst_outputs",
          {psel, penable, pwrite, paddr, pwdata, pstrb,
           rsp_valid, rsp_rdata, rsp_err}, 128'(0));
    check("rst_ready", 128'(req_ready), 128'(0));
    @(posedge pclk);
    #1;
    prstn = 1'b1;
    @(posedge pclk);
    #1;

    // Single write, zero-wait completer, cycle by cycle.
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0 +: AW] = 4'h2;
    req_wdata[0 +: DW] = 32'hA5A5_0F0F;
    req_strb[0 +: SW] = 4'hF;
    @(negedge pclk);
    check("s1_ready", 128'(req_ready), 128'(2'b01));
    check("s1_idle_psel", 128'({psel, penable}), 128'(0));
    @(posedge pclk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge pclk);
    check("s1_setup", 128'({psel, penable, paddr}),
          128'({1'b1, 1'b0, 4'h2}));
    @(negedge pclk);
    check("s1_access", 128'({psel, penable}), 128'(2'b11));
    @(negedge pclk);
    check("s1_rsp", 128'({rsp_valid, rsp_err}), 128'({2'b01, 1'b0}));
    check("s1_idle", 128'({psel, penable, paddr}),
          128'({1'b0, 1'b0, 4'h2}));
    @(posedge pclk);
    #1;

    // Read with 2 wait states.
    rd_base = 32'h0000_00FF;
    ws = 2;
    issue(0, 1'b0, 4'h0, 32'h0, 4'hF);
    drain();
    check("s2_rdata", 128'(rsp_rdata), 128'(32'h0000_00FF));

    // Slave error on write to addr 3, then a clean write.
    ws = 0;
    err_addr = 3;
    issue(0, 1'b1, 4'h3, 32'h1234_5678, 4'h5);
    issue(1, 1'b1, 4'h4, 32'h9ABC_DEF0, 4'hA);
    drain();
    check("s5_err_clear", 128'(rsp_err), 128'(0));
    err_addr = -1;

    // Sustained stream from both requesters.
    grant_q.delete();
    gcyc_q.delete();
    fork
      begin
        for (int k = 0; k < 3; k++)
          issue(0, 1'b1, 4'(k), 32'h1000_0000 + k, 4'h3);
      end
      begin
        for (int k = 0; k < 3; k++)
          issue(1, 1'b1, 4'(k + 8), 32'h2000_0000 + k, 4'hC);
      end
    join
    drain();
    check("s3_count", 128'(grant_q.size()), 128'(6));
    for (int j = 0; j < 6 && j < grant_q.size(); j++)
      check($sformatf("s3_order%0d", j), 128'(grant_q[j]), 128'(j % 2));
    for (int j = 1; j < 6 && j < gcyc_q.size(); j++)
      check($sformatf("s3_gap%0d", j),
            128'(gcyc_q[j] - gcyc_q[j-1]), 128'(2));

    // Hung completer: watchdog forces error, then requester 1.
    ws = 1000;
    grant_q.delete();
    fork
      issue(0, 1'b0, 4'h5, 32'h0, 4'hF);
      issue(1, 1'b0, 4'h6, 32'h0, 4'hF);
    join
    drain();
    check("s4_n", 128'(grant_q.size()), 128'(2));
    if (grant_q.size() == 2) begin
      check("s4_first", 128'(grant_q[0]), 128'(0));
      check("s4_next", 128'(grant_q[1]), 128'(1));
    end
    check("s4_err", 128'(rsp_err), 128'(1));

    // Asynchronous reset during ACCESS.
    issue(0, 1'b0, 4'h7, 32'h0, 4'hF);
    for (int k = 0; k < 10 && !(psel && penable); k++) @(negedge pclk);
    check("s6_in_access", 128'({psel, penable}), 128'(2'b11));
    prstn = 1'b0;
    #1;
    check("s6_rst_apb", 128'({psel, penable}), 128'(0));
    exp_q.delete();
    repeat (2) begin
      @(negedge pclk);
      check("s6_no_rsp", 128'(rsp_valid), 128'(0));
    end
    ws = 0;
    @(posedge pclk);
    #1;
    prstn = 1'b1;
    grant_q.delete();
    fork
      issue(0, 1'b1, 4'h8, 32'hCAFE_0000, 4'hF);
      issue(1, 1'b1, 4'h9, 32'hBEEF_0000, 4'h1);
    join
    drain();
    check("s6_n", 128'(grant_q.size()), 128'(2));
    if (grant_q.size() == 2) begin
      check("s6_first", 128'(grant_q[0]), 128'(0));
      check("s6_second", 128'(grant_q[1]), 128'(1));
    end

    repeat (3) @(posedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
